// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache/memory arbiter: FSM encoding, requester
// indices and a constant-width helper.
package mem_if_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority (lowest index) or round-robin starting at
// the supplied pointer. Produces no grant when disabled.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               mode,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = mode ? ((int'(ptr) + k) % NUM_REQ) : k;
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_fill.sv
// Arbitrates cache misses/write-throughs onto a pipelined fixed-latency main
// memory, issuing whole-line fills and steering returned words to the owner.
module mem_arbiter_fill
  import mem_if_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ARB_MODE        = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic [DATA_W-1:0]           fill_data,
  output logic [clog2(WORDS_PER_BLOCK)-1:0] fill_idx,
  output logic [NUM_REQ-1:0]          fill_we,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_enable,
  output logic                        mem_wr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_data_valid
);

  localparam int IDX_W = clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   icnt;
  logic [CNT_W-1:0]   rcnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic [ADDR_W-1:0]  arb_addr;
  logic [DATA_W-1:0]  arb_wdata;
  logic               arb_write;
  logic               arb_take;
  logic               ret_vld;
  logic               ret_last;
  logic               issue_last;
  logic [ADDR_W-1:0]  line_base;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .mode (ARB_MODE != 0),
    .en   (state == IDLE),
    .gnt  (arb_gnt)
  );

  always_comb begin
    arb_idx   = '0;
    arb_addr  = '0;
    arb_wdata = '0;
    arb_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        arb_idx   = PTR_W'(i);
        arb_addr  = req_addr[i*ADDR_W +: ADDR_W];
        arb_wdata = req_wdata[i*DATA_W +: DATA_W];
        arb_write = req_write[i];
      end
    end
  end

  assign arb_take   = |arb_gnt;
  // Returns only count while a fill is outstanding; late strobes are dropped.
  assign ret_vld    = mem_data_valid && (state == ISSUE || state == DRAIN);
  assign ret_last   = ret_vld && (rcnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign issue_last = (icnt == IDX_W'(WORDS_PER_BLOCK - 1));
  assign line_base  = {addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      icnt   <= '0;
      rcnt   <= '0;
      rr_ptr <= '0;
      owner  <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_take) begin
            grant <= arb_gnt;
            owner <= arb_idx;
            icnt  <= '0;
            rcnt  <= '0;
            state <= arb_write ? WRITE : ISSUE;
          end
        end
        ISSUE: begin
          icnt <= icnt + 1'b1;
          if (ret_vld) rcnt <= rcnt + 1'b1;
          if (issue_last) state <= ret_last ? DONE : DRAIN;
        end
        DRAIN: begin
          if (ret_vld) rcnt <= rcnt + 1'b1;
          if (ret_last) state <= DONE;
        end
        WRITE: state <= DONE;
        DONE: begin
          grant  <= '0;
          rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture p0: address/data held for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_take) begin
      addr_p0  <= arb_addr;
      wdata_p0 <= arb_wdata;
    end
  end

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == ISSUE) begin
      mem_enable = 1'b1;
      mem_addr   = line_base | {{(ADDR_W-OFF_W){1'b0}}, icnt, 1'b0};
    end else if (state == WRITE) begin
      mem_enable = 1'b1;
      mem_wr     = 1'b1;
      mem_addr   = addr_p0;
      mem_wdata  = wdata_p0;
    end
  end

  assign fill_we   = ret_vld ? grant : '0;
  assign fill_data = ret_vld ? mem_rdata : '0;
  assign fill_idx  = ret_vld ? rcnt[IDX_W-1:0] : '0;
  assign done      = (state == DONE) ? grant : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_fill.sv
// Directed bench for mem_arbiter_fill: fixed-priority instance with a
// 4-cycle pipelined memory model, plus a round-robin instance for grant order.
module tb_mem_arbiter_fill;
  import mem_if_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // fixed-priority DUT
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  grant, fill_we, done;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_idx;
  logic        busy, mem_enable, mem_wr, mem_data_valid;
  logic        stray_vld = 1'b0;

  // round-robin DUT
  logic [1:0]  r1_req_valid = '0, r1_req_write = '0;
  logic [31:0] r1_req_addr = '0, r1_req_wdata = '0;
  logic [1:0]  r1_grant, r1_fill_we, r1_done;
  logic [15:0] r1_fill_data, r1_mem_addr, r1_mem_wdata;
  logic [15:0] r1_mem_rdata = '0;
  logic [2:0]  r1_fill_idx;
  logic        r1_busy, r1_mem_enable, r1_mem_wr;
  logic        r1_mem_data_valid = 1'b0;

  mem_arbiter_fill #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
    .fill_data(fill_data), .fill_idx(fill_idx), .fill_we(fill_we), .done(done),
    .busy(busy), .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  mem_arbiter_fill #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(r1_req_valid), .req_write(r1_req_write),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .grant(r1_grant),
    .fill_data(r1_fill_data), .fill_idx(r1_fill_idx), .fill_we(r1_fill_we), .done(r1_done),
    .busy(r1_busy), .mem_addr(r1_mem_addr), .mem_enable(r1_mem_enable), .mem_wr(r1_mem_wr),
    .mem_wdata(r1_mem_wdata), .mem_rdata(r1_mem_rdata), .mem_data_valid(r1_mem_data_valid)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[15:8]};
  endfunction

  // pipelined fixed-latency memory model
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mem_enable & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_data_valid = pv[LAT-1] | stray_vld;
  assign mem_rdata      = pv[LAT-1] ? mem_word(pa[LAT-1]) : 16'h0000;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Assumes the request is already presented; arbitration happens at the next edge.
  task automatic serve_read(input int r, input logic [15:0] base);
    int issued, nret, first_c, last_c;
    bit got_done;
    logic [1:0] g;
    g = 2'b01 << r;
    issued = 0; nret = 0; first_c = -1; last_c = -1; got_done = 0;
    tick;
    check("rd_grant", grant, g);
    for (int c = 0; c < 60 && !got_done; c++) begin
      if (mem_enable) begin
        check("rd_addr", mem_addr, base + 16'(2 * issued));
        check("rd_wr_low", mem_wr, 0);
        if (first_c < 0) first_c = c;
        last_c = c;
        issued++;
      end
      if (fill_we != 2'b00) begin
        check("fill_we", fill_we, g);
        check("fill_idx", fill_idx, nret);
        check("fill_data", fill_data, mem_word(base + 16'(2 * nret)));
        nret++;
      end
      if (done != 2'b00) begin
        check("rd_done", done, g);
        got_done = 1;
        req_valid[r] = 1'b0;
      end
      tick;
    end
    check("rd_done_seen", got_done, 1);
    check("rd_issue_count", issued, 8);
    check("rd_issue_span", last_c - first_c, 7);
    check("rd_ret_count", nret, 8);
    check("rd_done_once", done, 0);
    check("rd_idle_busy", busy, 0);
    check("rd_idle_grant", grant, 0);
  endtask

  initial begin
    int nret, stray_we;
    logic [1:0] rr_exp;

    // reset state
    tick; tick;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_enable, 0);
    check("rst_done", done, 0);
    check("rst_fill_we", fill_we, 0);
    check("rst_rr_grant", r1_grant, 0);
    rst = 1'b0;
    tick;

    // single ICACHE fill at 0x0036 -> line 0x0030..0x003E
    req_valid = 2'b01;
    req_addr[REQ_ICACHE*16 +: 16] = 16'h0036;
    serve_read(REQ_ICACHE, 16'h0030);

    // simultaneous requests, fixed priority: ICACHE then DCACHE
    req_valid = 2'b11;
    req_addr[REQ_ICACHE*16 +: 16] = 16'h0104;
    req_addr[REQ_DCACHE*16 +: 16] = 16'h1000;
    serve_read(REQ_ICACHE, 16'h0100);
    check("pri_dc_still_req", req_valid, 2'b10);
    serve_read(REQ_DCACHE, 16'h1000);

    // DCACHE write-through
    req_valid[REQ_DCACHE] = 1'b1;
    req_write[REQ_DCACHE] = 1'b1;
    req_addr[REQ_DCACHE*16 +: 16]  = 16'h2002;
    req_wdata[REQ_DCACHE*16 +: 16] = 16'hBEEF;
    tick;
    check("wr_grant", grant, 2'b10);
    check("wr_mem_wr", mem_wr, 1);
    check("wr_mem_en", mem_enable, 1);
    check("wr_addr", mem_addr, 16'h2002);
    check("wr_wdata", mem_wdata, 16'hBEEF);
    check("wr_done_early", done, 0);
    tick;
    check("wr_done", done, 2'b10);
    check("wr_en_off", mem_enable, 0);
    check("wr_no_fill", fill_we, 0);
    req_valid = 2'b00;
    req_write = 2'b00;
    tick;
    check("wr_idle", busy, 0);

    // stray valid in IDLE
    stray_vld = 1'b1;
    #1;
    check("stray_idle_we", fill_we, 0);
    check("stray_idle_data", fill_data, 0);
    tick;
    stray_vld = 1'b0;
    check("stray_idle_busy", busy, 0);
    check("stray_idle_grant", grant, 0);

    // reset after three returned words
    req_valid = 2'b01;
    req_addr[REQ_ICACHE*16 +: 16] = 16'h0400;
    tick;
    check("rm_grant", grant, 2'b01);
    nret = 0;
    for (int c = 0; c < 40 && nret < 3; c++) begin
      if (fill_we != 2'b00) nret++;
      if (nret < 3) tick;
    end
    check("rm_three_returned", nret, 3);
    rst = 1'b1;
    #1;
    check("rm_grant0", grant, 0);
    check("rm_busy0", busy, 0);
    check("rm_en0", mem_enable, 0);
    check("rm_addr0", mem_addr, 0);
    check("rm_we0", fill_we, 0);
    req_valid = 2'b00;
    tick;
    rst = 1'b0;
    stray_we = 0;
    for (int c = 0; c < 12; c++) begin
      stray_vld = (c == 8 || c == 9);
      #1;
      if (fill_we != 2'b00) stray_we++;
      tick;
    end
    stray_vld = 1'b0;
    check("rm_late_we", stray_we, 0);
    check("rm_busy", busy, 0);
    req_valid = 2'b01;
    req_addr[REQ_ICACHE*16 +: 16] = 16'h0512;
    serve_read(REQ_ICACHE, 16'h0510);

    // round-robin instance: both requesters held, expect alternation
    r1_req_valid = 2'b11;
    r1_req_write = 2'b11;
    r1_req_addr  = {16'h3102, 16'h3000};
    r1_req_wdata = {16'h2222, 16'h1111};
    for (int t = 0; t < 4; t++) begin
      rr_exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick;
      check("rr_grant", r1_grant, rr_exp);
      check("rr_wr", r1_mem_wr, 1);
      check("rr_addr", r1_mem_addr, (t % 2 == 0) ? 16'h3000 : 16'h3102);
      tick;
      check("rr_done", r1_done, rr_exp);
      tick;
      check("rr_bubble", r1_busy, 0);
    end
    r1_req_valid = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_fill.md
Name: mem_arbiter_fill

Overview:
- Parametrised arbiter and block-fill controller between N cache requesters and the shared multi-cycle main memory (memory4c-style: pipelined, fixed latency, data_valid strobe).
- Generalises the current I-cache-only miss path: adds D-cache and further ports, multi-word line fill, single-word write-through, and fixed or round-robin arbitration.
- Sits between the cache instances and main memory. It drives the memory address/enable/wr, and steers returned words to the granted cache with a word index.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 = ICACHE, 1 = DCACHE.
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- WORDS_PER_BLOCK, 8, words per cache line; power of 2, minimum 2.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  miss/write request; held until matching done pulse.
- req_write  in  NUM_REQ  1 = single-word write, 0 = line fill.
- req_addr  in  NUM_REQ*ADDR_W  byte address per requester, packed, requester 0 in LSBs.
- req_wdata  in  NUM_REQ*DATA_W  write data per requester, packed.
- grant  out  NUM_REQ  one-hot; current owner.
- fill_data  out  DATA_W  returned memory word.
- fill_idx  out  log2(WORDS_PER_BLOCK)  word offset of fill_data within the line.
- fill_we  out  NUM_REQ  one-hot write strobe into owning cache.
- done  out  NUM_REQ  one-cycle completion pulse.
- busy  out  1  state != IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_rdata valid this cycle.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; issue and return counters go to 0.
  - Round-robin pointer goes to 0.
  - All outputs go to 0.
  - An in-flight fill is abandoned. Late mem_data_valid is ignored.
- FSM states: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - Arbitrates only here, among asserted req_valid bits.
  - ARB_MODE 0: lowest asserted index wins.
  - ARB_MODE 1: first asserted index at or after the pointer, wrapping.
  - Winner is registered as the grant (visible next cycle), together with its address and wdata.
  - If the winner's req_write=1, go to WRITE; otherwise go to ISSUE.
- Line base address: req_addr with the low log2(WORDS_PER_BLOCK)+1 bits cleared (word = 2 bytes).
- ISSUE:
  - Runs exactly WORDS_PER_BLOCK cycles, mem_enable=1 and mem_wr=0 on each.
  - Cycle i drives mem_addr = base + 2*i; the issue counter wraps to 0 after the last word.
  - Then go to DRAIN. If all words have already returned, go straight to DONE.
- Returns (ISSUE or DRAIN):
  - Each mem_data_valid gives fill_data = mem_rdata, fill_idx = return count, and fill_we = grant, all in the same cycle (combinational).
  - Returns arrive in issue order.
  - When return count reaches WORDS_PER_BLOCK, go to DONE.
- mem_data_valid in IDLE, WRITE or DONE: ignored, no fill_we.
- WRITE:
  - One cycle: mem_enable=1, mem_wr=1, mem_addr = registered address (not aligned), mem_wdata = registered wdata.
  - Then go to DONE.
- DONE:
  - One cycle: done = grant.
  - Round-robin pointer = owner+1, modulo NUM_REQ.
  - Then IDLE with grant cleared.
  - The earliest re-arbitration is the cycle after DONE, so back-to-back requests have one idle bubble.
- A req_valid drop mid-transaction has no effect; the transaction completes.
- mem_enable=0, mem_wr=0 and mem_addr=0 whenever not in ISSUE or WRITE.
- Latency:
  - Read fill: 1 (arbitrate) + WORDS_PER_BLOCK + memory latency + 1 (DONE) cycles.
  - Write: 3 cycles from req_valid to done.

Decomposition:
- Shared package mem_if_pkg holds:
  - state encoding enum;
  - requester index constants REQ_ICACHE=0, REQ_DCACHE=1;
  - function clog2.
- One sub-module: rr_arbiter (req vector, pointer, mode, enable -> one-hot grant). The FSM, counters and datapath stay in the top module.

Test Plan:
- Single I fill:
  - Stimulus: req_valid=01, addr 0x0036, memory latency 4.
  - Response: grant=01; mem_addr 0x0030..0x003E over 8 consecutive cycles; 8 fill_we[0] pulses with fill_idx 0..7 and data matching memory; done[0] exactly once; busy low afterwards.
- Simultaneous requests, ARB_MODE 0:
  - Stimulus: req_valid=11 (DCACHE fill at 0x1000).
  - Response: ICACHE served first; DCACHE granted the cycle after done[0]; base 0x1000.
- Round-robin, ARB_MODE 1:
  - Stimulus: req_valid held at 11 for 4 transactions.
  - Response: grant order 01, 10, 01, 10.
- Write-through:
  - Stimulus: DCACHE req_write=1, addr 0x2002, wdata 0xBEEF.
  - Response: one cycle with mem_wr=1, mem_enable=1, mem_addr=0x2002, mem_wdata=0xBEEF; done[1] 2 cycles later; no fill_we.
- Reset mid-fill:
  - Stimulus: assert rst after 3 returned words, release, then 2 stray mem_data_valid pulses.
  - Response: outputs 0 immediately; no fill_we for the stray pulses; a fresh request completes normally.
- Stray valid:
  - Stimulus: mem_data_valid pulse in IDLE.
  - Response: fill_we stays 0, state stays IDLE.
